// File: rtl/bm_dag_log_sched.sv
// bm_dag_log_sched
//   Round-robin scheduler that shares one BITS-wide logic-op unit among
//   four requesters. In IDLE it picks a winner, latches the winner's
//   opcode and operands, and grants it for one cycle (EXEC). It then
//   presents the result in RESP until the consumer acknowledges it.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | sample req; on a hit, latch winner op/a/b/id and raise gnt
//   EXEC  | gnt one-hot for this cycle; result loaded into out at the edge
//   RESP  | out_valid high, out/out_id held; out_ack returns to IDLE
//
// Ports:
//   clock, reset_n : rising-edge clock, async active-low reset
//   req     [4]    : request per requester
//   op_flat [8]    : 2-bit opcode per requester
//   a_flat, b_flat : BITS-wide operands per requester
//   gnt     [4]    : one-hot grant, one cycle per accepted request
//   out_valid, out_id, out : result handshake, owner index, result value
//   out_ack        : consumer accepts the result
module bm_dag_log_sched #(
  parameter int BITS = 2,
  parameter int NREQ = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op_flat,
  input  logic [NREQ*BITS-1:0] a_flat,
  input  logic [NREQ*BITS-1:0] b_flat,
  output logic [NREQ-1:0]      gnt,
  output logic                 out_valid,
  output logic [1:0]           out_id,
  output logic [BITS-1:0]      out,
  input  logic                 out_ack
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [1:0]      rr_ptr;
  logic [1:0]      win;
  logic            win_vld;
  logic [1:0]      op_q;
  logic [BITS-1:0] a_q, b_q;
  logic [BITS-1:0] res;

  // First set request scanning upward from rr_ptr, wrapping at 4.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!win_vld && req[rr_ptr + 2'(k)]) begin
        win     = rr_ptr + 2'(k);
        win_vld = 1'b1;
      end
    end
  end

  // The b^b term is always zero, so op 11 reduces to a|b; kept in the
  // original form so the datapath reads like the benchmark's DAG.
  always_comb begin
    res = '0;
    case (op_q)
      2'b00:   res = a_q & b_q;
      2'b01:   res = a_q ^ b_q;
      2'b10:   res = a_q | b_q;
      default: res = (a_q & b_q) | (a_q ^ b_q) | (b_q ^ b_q);
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (out_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt       <= '0;
      out_valid <= 1'b0;
      out_id    <= 2'd0;
      out       <= '0;
      rr_ptr    <= 2'd0;
      op_q      <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            op_q   <= op_flat[{win, 1'b0} +: 2];
            a_q    <= a_flat[win*BITS +: BITS];
            b_q    <= b_flat[win*BITS +: BITS];
            out_id <= win;
            gnt    <= NREQ'(1) << win;
          end
        end
        EXEC: begin
          gnt       <= '0;
          out       <= res;
          out_valid <= 1'b1;
        end
        RESP: begin
          if (out_ack) begin
            out_valid <= 1'b0;
            rr_ptr    <= out_id + 2'd1;
          end
        end
        default: gnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bm_dag_log_sched.sv
module tb_bm_dag_log_sched;

  localparam int BITS = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] op_flat = '0;
  logic [7:0] a_flat = '0;
  logic [7:0] b_flat = '0;
  logic [3:0] gnt;
  logic       out_valid;
  logic [1:0] out_id;
  logic [1:0] out;
  logic       out_ack = 1'b0;

  bm_dag_log_sched #(.BITS(BITS), .NREQ(4)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .op_flat(op_flat),
    .a_flat(a_flat), .b_flat(b_flat), .gnt(gnt), .out_valid(out_valid),
    .out_id(out_id), .out(out), .out_ack(out_ack)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] id;
    logic [1:0] res;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [3:0] req;
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] exp_w;
    logic [1:0] exp_out;
  } vec_t;

  int last_gnt = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model(input logic [7:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input int w);
    logic [1:0] o, x, y;
    o = op[2*w +: 2];
    x = a[2*w +: 2];
    y = b[2*w +: 2];
    case (o)
      2'b00:   return x & y;
      2'b01:   return x ^ y;
      2'b10:   return x | y;
      default: return x | y;
    endcase
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    out_ack = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    sb.delete();
    last_gnt = -1;
    @(negedge clock);
  endtask

  // Waits (bounded) for a grant; returns 1 if one was seen.
  task automatic wait_gnt(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (gnt != 4'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL gnt_timeout: got no grant, expected one (t=%0t)", $time);
    end
  endtask

  // One transaction, called aligned to a negedge.
  task automatic run_txn(input logic [3:0] r, input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] exp_w,
                         input logic [1:0] exp_out, input bit hold, input bit chk_gap,
                         input int ack_delay);
    bit   seen;
    sb_t  e;
    logic [1:0] o_first;
    req = r; op_flat = op; a_flat = a; b_flat = b;
    wait_gnt(seen);
    if (!seen) return;
    chk("gnt_onehot", gnt, 32'(4'b0001 << exp_w));
    if (chk_gap && last_gnt >= 0) chk("gnt_interval", cyc - last_gnt, 3);
    last_gnt = cyc;
    sb.push_back('{id: exp_w, res: exp_out});
    if (!hold) req = '0;
    @(negedge clock);
    chk("gnt_single_cycle", gnt, 0);
    chk("out_valid_rise", out_valid, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_id", out_id, e.id);
      chk("out", out, e.res);
    end
    o_first = out;
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clock);
      chk("hold_out", out, o_first);
      chk("hold_valid", out_valid, 1);
    end
    out_ack = 1'b1;
    @(negedge clock);
    out_ack = 1'b0;
    chk("valid_after_ack", out_valid, 0);
  endtask

  vec_t vt[5];

  initial begin
    bit   seen;
    logic [7:0] op3, a3, b3;

    vt[0] = '{4'b0001, 8'h00, 8'h03, 8'h01, 2'd0, 2'b01};
    vt[1] = '{4'b0100, 8'h00, 8'h20, 8'h30, 2'd2, 2'b10};
    vt[2] = '{4'b0100, 8'h10, 8'h20, 8'h30, 2'd2, 2'b01};
    vt[3] = '{4'b0100, 8'h20, 8'h20, 8'h30, 2'd2, 2'b11};
    vt[4] = '{4'b0100, 8'h30, 8'h20, 8'h30, 2'd2, 2'b11};

    repeat (2) @(negedge clock);
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out", out, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic transaction and opcode sweep
    foreach (vt[i])
      run_txn(vt[i].req, vt[i].op, vt[i].a, vt[i].b, vt[i].exp_w, vt[i].exp_out, 1'b0, 1'b0, 0);

    // All four requesting continuously: 0,1,2,3,0 at 3-cycle spacing
    do_reset();
    op3 = 8'b11_10_01_00; a3 = 8'b10_01_11_10; b3 = 8'b11_11_01_01;
    for (int k = 0; k < 5; k++)
      run_txn(4'b1111, op3, a3, b3, 2'(k % 4), model(op3, a3, b3, k % 4), 1'b1, 1'b1, 0);
    req = '0;

    // Back-pressure with operand churn and pending requests
    do_reset();
    req = 4'b0001; op_flat = 8'h01; a_flat = 8'h03; b_flat = 8'h01;
    wait_gnt(seen);
    if (seen) begin
      chk("bp_gnt", gnt, 4'b0001);
      req = 4'b0110;
      @(negedge clock);
      chk("bp_valid", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
        a_flat = a_flat ^ 8'h03;
        b_flat = b_flat ^ 8'h02;
        @(negedge clock);
        chk("bp_out", out, 2'b10);
        chk("bp_id", out_id, 0);
        chk("bp_no_gnt", gnt, 0);
      end
      out_ack = 1'b1;
      @(negedge clock);
      out_ack = 1'b0;
      run_txn(4'b0110, 8'h08, 8'h0C, 8'h04, 2'd1, model(8'h08, 8'h0C, 8'h04, 1), 1'b0, 1'b0, 0);
    end

    // Asynchronous reset while a result is waiting
    do_reset();
    run_txn(4'b0001, 8'h02, 8'h01, 8'h02, 2'd0, 2'b11, 1'b0, 1'b0, 0);
    req = 4'b0010; op_flat = 8'h00; a_flat = 8'h0C; b_flat = 8'h0C;
    wait_gnt(seen);
    req = '0;
    @(negedge clock);
    chk("pre_rst_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_gnt", gnt, 0);
    chk("arst_out", out, 0);
    chk("arst_out_id", out_id, 0);
    @(negedge clock);
    reset_n = 1'b1;
    sb.delete();
    @(negedge clock);
    run_txn(4'b1001, 8'h00, 8'hFF, 8'h7F, 2'd0, 2'b11, 1'b0, 1'b0, 0);
    run_txn(4'b1000, 8'hC0, 8'h40, 8'h80, 2'd3, 2'b11, 1'b0, 1'b0, 0);

    // Spurious ack in IDLE, and a request pulse that misses the sampling edge
    out_ack = 1'b1;
    repeat (2) begin
      @(negedge clock);
      chk("spur_ack_valid", out_valid, 0);
      chk("spur_ack_gnt", gnt, 0);
    end
    out_ack = 1'b0;
    @(posedge clock);
    #1 req = 4'b0100;
    @(negedge clock);
    req = '0;
    repeat (3) begin
      @(negedge clock);
      chk("pulse_no_gnt", gnt, 0);
      chk("pulse_no_valid", out_valid, 0);
    end

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
